// File: rtl/ir_nec_transmitter_if.sv
// rtl/ir_nec_transmitter_if.sv - frame request and status bundle for the NEC IR transmitter
interface ir_nec_transmitter_if;
  logic       start;
  logic [7:0] address;
  logic [7:0] command;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output address,
    output command,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  address,
    input  command,
    output busy,
    output done
  );
endinterface

// File: rtl/ir_nec_transmitter.sv
// rtl/ir_nec_transmitter.sv - NEC IR frame encoder modulating an external ~38 kHz carrier
// All frame timing is counted in synchronised carrier rising edges, so a stalled carrier freezes the frame.
module ir_nec_transmitter #(
  parameter int UNIT_CYCLES        = 21,
  parameter int LEADER_MARK_UNITS  = 16,
  parameter int LEADER_SPACE_UNITS = 8,
  parameter int ONE_SPACE_UNITS    = 3,
  parameter int CNT_W              = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    carrier_in,
  ir_nec_transmitter_if.slave     ctrl,
  output logic                    ir_out
);

  localparam logic [CNT_W-1:0] UNIT_LAST         = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEADER_MARK_LAST  = CNT_W'(LEADER_MARK_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEADER_SPACE_LAST = CNT_W'(LEADER_SPACE_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_SPACE_LAST    = CNT_W'(ONE_SPACE_UNITS * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             carrier_meta;
  logic             carrier_sync;
  logic             carrier_prev;
  logic             tick;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] last_cnt;
  logic [31:0]      shift;
  logic [31:0]      shift_n;
  logic [4:0]       bit_idx;
  logic [4:0]       idx_n;
  logic             done_n;
  logic             busy_q;
  logic             done_q;
  logic             ir_q;
  logic             is_mark;

  assign tick    = carrier_sync & ~carrier_prev;
  assign is_mark = (state == LEADER_MARK) || (state == BIT_MARK) || (state == STOP_MARK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carrier_meta <= 1'b0;
      carrier_sync <= 1'b0;
      carrier_prev <= 1'b0;
    end else begin
      carrier_meta <= carrier_in;
      carrier_sync <= carrier_meta;
      carrier_prev <= carrier_sync;
    end
  end

  always_comb begin
    last_cnt = UNIT_LAST;
    case (state)
      LEADER_MARK:  last_cnt = LEADER_MARK_LAST;
      LEADER_SPACE: last_cnt = LEADER_SPACE_LAST;
      BIT_SPACE:    last_cnt = shift[0] ? ONE_SPACE_LAST : UNIT_LAST;
      default:      last_cnt = UNIT_LAST;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = tick_cnt;
    shift_n = shift;
    idx_n   = bit_idx;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (ctrl.start) begin
        shift_n = {~ctrl.command, ctrl.command, ~ctrl.address, ctrl.address};
        idx_n   = 5'd0;
        cnt_n   = '0;
        state_n = LEADER_MARK;
      end
    end else if (tick) begin
      if (tick_cnt == last_cnt) begin
        cnt_n = '0;
        case (state)
          LEADER_MARK:  state_n = LEADER_SPACE;
          LEADER_SPACE: state_n = BIT_MARK;
          BIT_MARK:     state_n = BIT_SPACE;
          BIT_SPACE: begin
            if (bit_idx == 5'd31) begin
              state_n = STOP_MARK;
            end else begin
              state_n = BIT_MARK;
              shift_n = shift >> 1;
              idx_n   = bit_idx + 5'd1;
            end
          end
          STOP_MARK: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end else begin
        cnt_n = tick_cnt + 1'b1;
      end
    end
  end

  // ir_out gates the delayed carrier copy, so a pulse whose rising tick ends a mark never starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ir_q     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= cnt_n;
      shift    <= shift_n;
      bit_idx  <= idx_n;
      busy_q   <= (state_n != IDLE);
      done_q   <= done_n;
      ir_q     <= carrier_prev & is_mark;
    end
  end

  assign ctrl.busy = busy_q;
  assign ctrl.done = done_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// tb/tb_ir_nec_transmitter.sv - scoreboard bench decoding ir_out bursts back into NEC frames
module tb_ir_nec_transmitter;
  logic clk = 1'b0;
  logic reset;
  logic carrier_in = 1'b1;
  logic ir_out;
  logic hold = 1'b0;
  int   ph = 0;

  ir_nec_transmitter_if ctrl_if();

  ir_nec_transmitter #(.UNIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .carrier_in (carrier_in),
    .ctrl       (ctrl_if),
    .ir_out     (ir_out)
  );

  always #5 clk = ~clk;

  // carrier = clk/10, high for phases 0..4; hold freezes it in the low half
  always @(negedge clk) begin
    if (!hold) begin
      ph = (ph == 9) ? 0 : ph + 1;
      carrier_in = (ph < 5);
    end
  end

  int crise = 0;
  always @(posedge carrier_in) crise = crise + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int          bursts[$];
  int          gaps[$];
  int          burst_cnt = 0;
  int          fall_rise = 0;
  int          rise0 = 0;
  int          frames_seen = 0;
  logic        prev_ir = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    logic [31:0] exp_word;
    logic [31:0] word;
    int          bad;
    if (!reset) begin
      bursts.delete();
      gaps.delete();
      burst_cnt = 0;
      prev_ir   = 1'b0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (ctrl_if.busy && !prev_busy) begin
        bursts.delete();
        gaps.delete();
        burst_cnt = 0;
        rise0     = crise;
      end
      if (ir_out && !prev_ir) begin
        if (burst_cnt > 0 && (crise - fall_rise) >= 2) begin
          bursts.push_back(burst_cnt);
          gaps.push_back(crise - fall_rise - 1);
          burst_cnt = 1;
        end else begin
          burst_cnt = burst_cnt + 1;
        end
      end
      if (!ir_out && prev_ir) fall_rise = crise;
      if (ctrl_if.done) begin
        frames_seen = frames_seen + 1;
        check("done_single_cycle", prev_done, 0);
        check("busy_low_with_done", ctrl_if.busy, 0);
        bursts.push_back(burst_cnt);
        check("frame_expected", exp_q.size() > 0, 1);
        exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        check("burst_count", bursts.size(), 34);
        check("gap_count", gaps.size(), 33);
        if (bursts.size() == 34 && gaps.size() == 33) begin
          check("leader_mark_pulses", bursts[0], 32);
          check("leader_space_periods", gaps[0], 16);
          bad = 0;
          for (int i = 1; i < 34; i++) if (bursts[i] != 2) bad = bad + 1;
          check("bit_and_stop_marks_bad", bad, 0);
          bad  = 0;
          word = 32'h0;
          for (int i = 0; i < 32; i++) begin
            if (gaps[i+1] == 6) word[i] = 1'b1;
            else if (gaps[i+1] != 2) bad = bad + 1;
          end
          check("bit_spaces_bad", bad, 0);
          check("frame_word", word, exp_word);
        end
        check("frame_carrier_edges", crise - rise0, 242);
        bursts.delete();
        gaps.delete();
        burst_cnt = 0;
      end
      prev_ir   = ir_out;
      prev_busy = ctrl_if.busy;
      prev_done = ctrl_if.done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    do begin
      cyc(1);
      guard = guard + 1;
    end while (ph != p && guard < 40);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] c);
    ctrl_if.address = a;
    ctrl_if.command = c;
    ctrl_if.start   = 1'b1;
    cyc(1);
    ctrl_if.start   = 1'b0;
    check("busy_after_start", ctrl_if.busy, 1);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!ctrl_if.done && g < 8000) begin
      cyc(1);
      g = g + 1;
    end
    if (g >= 8000) check("done_timeout", 0, 1);
  endtask

  initial begin
    int bad;
    reset           = 1'b0;
    ctrl_if.start   = 1'b0;
    ctrl_if.address = 8'h00;
    ctrl_if.command = 8'h00;

    cyc(2);
    ctrl_if.start = 1'b1;
    bad = 0;
    repeat (8) begin
      cyc(1);
      if (ctrl_if.busy || ctrl_if.done || ir_out) bad = bad + 1;
    end
    ctrl_if.start = 1'b0;
    check("reset_outputs_quiet", bad, 0);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      cyc(1);
      if (ctrl_if.busy || ctrl_if.done || ir_out) bad = bad + 1;
    end
    check("idle_after_reset", bad, 0);

    wait_phase(3);
    exp_q.push_back(32'hBA45FF00);
    send(8'h00, 8'h45);
    cyc(49);
    send(8'hFF, 8'h99);
    wait_done();
    cyc(1);
    exp_q.push_back(32'hCB34ED12);
    send(8'h12, 8'h34);
    wait_done();

    cyc(20);
    wait_phase(3);
    send(8'h00, 8'h45);
    cyc(980);
    reset = 1'b0;
    #1;
    check("reset_midframe_ir_out", ir_out, 0);
    check("reset_midframe_busy", ctrl_if.busy, 0);
    cyc(5);
    reset = 1'b1;
    cyc(5);
    wait_phase(3);
    exp_q.push_back(32'hBA45FF00);
    send(8'h00, 8'h45);
    wait_done();

    cyc(20);
    wait_phase(3);
    exp_q.push_back(32'hF00F5AA5);
    send(8'hA5, 8'h0F);
    cyc(400);
    wait_phase(6);
    hold = 1'b1;
    bad = 0;
    repeat (1000) begin
      cyc(1);
      if (!ctrl_if.busy || ctrl_if.done || ir_out) bad = bad + 1;
    end
    check("frozen_in_leader_space", bad, 0);
    hold = 1'b0;
    wait_done();

    cyc(20);
    check("frames_completed", frames_seen, 4);
    check("expected_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
